// File: rtl/pacman_pkg.sv
// pacman_pkg: shared headings, FSM encodings, colours and helpers for the Pac-Man motion block
package pacman_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_Q_TURN = 2'd1;
   localparam logic [1:0] S_Q_FWD  = 2'd2;

   localparam logic [11:0] COLOR_PACMAN = 12'hFF0;
   localparam logic [11:0] COLOR_WALL   = 12'h00F;
   localparam logic [11:0] COLOR_BG     = 12'h000;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } pos_t;

   // Button priority: right > left > up > down
   function automatic logic [1:0] btn_dir(input logic r, input logic l, input logic u);
      return r ? DIR_RIGHT : l ? DIR_LEFT : u ? DIR_UP : DIR_DOWN;
   endfunction

endpackage

// File: rtl/pacman_next_pos.sv
// pacman_next_pos: one-step candidate position with edge clamp or tunnel wrap
module pacman_next_pos
   import pacman_pkg::*;
#(
   parameter int X_MIN  = 150,
   parameter int X_MAX  = 770,
   parameter int Y_MIN  = 34,
   parameter int Y_MAX  = 484,
   parameter int STEP   = 2,
   parameter int WRAP_X = 1,
   parameter int WRAP_Y = 0
) (
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [1:0] dir,
   output pos_t       cand
);

   logic [10:0] x_inc, y_inc;
   logic [9:0]  x_right, x_left, y_down, y_up;

   // Decrements compare first so the subtraction can never wrap below zero
   always_comb begin
      x_inc   = {1'b0, x} + 11'(STEP);
      y_inc   = {1'b0, y} + 11'(STEP);
      x_right = (x_inc > 11'(X_MAX)) ? ((WRAP_X != 0) ? 10'(X_MIN) : 10'(X_MAX)) : x_inc[9:0];
      x_left  = ({1'b0, x} < 11'(X_MIN + STEP)) ? ((WRAP_X != 0) ? 10'(X_MAX) : 10'(X_MIN)) : x - 10'(STEP);
      y_down  = (y_inc > 11'(Y_MAX)) ? ((WRAP_Y != 0) ? 10'(Y_MIN) : 10'(Y_MAX)) : y_inc[9:0];
      y_up    = ({1'b0, y} < 11'(Y_MIN + STEP)) ? ((WRAP_Y != 0) ? 10'(Y_MAX) : 10'(Y_MIN)) : y - 10'(STEP);
      cand.x  = (dir == DIR_RIGHT) ? x_right : (dir == DIR_LEFT) ? x_left : x;
      cand.y  = (dir == DIR_DOWN) ? y_down : (dir == DIR_UP) ? y_up : y;
   end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// pacman_motion_ctrl: tick-driven sprite mover with buffered turns and wall-query handshake
module pacman_motion_ctrl
   import pacman_pkg::*;
#(
   parameter int X_MIN   = 150,
   parameter int X_MAX   = 770,
   parameter int Y_MIN   = 34,
   parameter int Y_MAX   = 484,
   parameter int X_RESET = 450,
   parameter int Y_RESET = 250,
   parameter int STEP    = 2,
   parameter int WRAP_X  = 1,
   parameter int WRAP_Y  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move_tick,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic       wall_req,
   output logic [9:0] wall_x,
   output logic [9:0] wall_y,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [1:0] dir,
   output logic       moving,
   output logic [1:0] anim_frame
);

   logic [1:0] state, pend_dir, turn_dir, q_dir;
   logic       pend_valid, take_turn;
   pos_t       cand;

   // Turn candidates only come from IDLE; every other query is for the current heading
   assign take_turn = pend_valid && (pend_dir != dir);
   assign q_dir     = (state == S_IDLE && take_turn) ? pend_dir : dir;

   pacman_next_pos #(
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .STEP(STEP), .WRAP_X(WRAP_X), .WRAP_Y(WRAP_Y)
   ) u_next_pos (
      .x(xpos), .y(ypos), .dir(q_dir), .cand(cand)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         xpos       <= 10'(X_RESET);
         ypos       <= 10'(Y_RESET);
         dir        <= DIR_RIGHT;
         turn_dir   <= DIR_RIGHT;
         pend_dir   <= DIR_RIGHT;
         pend_valid <= 1'b0;
         moving     <= 1'b0;
         anim_frame <= 2'd0;
         wall_req   <= 1'b0;
         wall_x     <= 10'(X_RESET);
         wall_y     <= 10'(Y_RESET);
      end else begin
         case (state)
            S_IDLE: if (move_tick) begin
               wall_req <= 1'b1;
               wall_x   <= cand.x;
               wall_y   <= cand.y;
               if (take_turn) begin
                  state    <= S_Q_TURN;
                  turn_dir <= pend_dir;
               end else begin
                  state      <= S_Q_FWD;
                  pend_valid <= 1'b0;
               end
            end
            S_Q_TURN: if (wall_ack) begin
               if (!wall_hit) begin
                  state      <= S_IDLE;
                  wall_req   <= 1'b0;
                  dir        <= turn_dir;
                  pend_valid <= 1'b0;
                  xpos       <= wall_x;
                  ypos       <= wall_y;
                  moving     <= 1'b1;
                  anim_frame <= anim_frame + 2'd1;
               end else begin
                  // Turn blocked: stays queued, fall back to a forward query
                  state  <= S_Q_FWD;
                  wall_x <= cand.x;
                  wall_y <= cand.y;
               end
            end
            S_Q_FWD: if (wall_ack) begin
               state    <= S_IDLE;
               wall_req <= 1'b0;
               if (!wall_hit) begin
                  xpos       <= wall_x;
                  ypos       <= wall_y;
                  moving     <= 1'b1;
                  anim_frame <= anim_frame + 2'd1;
               end else begin
                  moving <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               wall_req <= 1'b0;
            end
         endcase
         if (up || down || left || right) begin
            pend_dir   <= btn_dir(right, left, up);
            pend_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// tb_pacman_motion_ctrl: directed scoreboard bench for pacman_motion_ctrl
module tb_pacman_motion_ctrl;

   typedef struct {
      int x;
      int y;
   } exp_t;

   localparam int XMIN = 150, XMAX = 770, YMIN = 34, YMAX = 484, S = 2, WX = 1, WY = 0;

   logic       clk = 1'b0, rst = 1'b1, move_tick = 1'b0;
   logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic       wall_ack = 1'b0, wall_hit = 1'b0;
   logic       wall_req, moving;
   logic [9:0] wall_x, wall_y, xpos, ypos;
   logic [1:0] dir, anim_frame;

   int   total = 0, bad = 0;
   int   ex = 450, ey = 250, ed = 0, ea = 0;
   exp_t sb[$];

   pacman_motion_ctrl dut (
      .clk(clk), .rst(rst), .move_tick(move_tick),
      .up(up), .down(down), .left(left), .right(right),
      .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
      .wall_ack(wall_ack), .wall_hit(wall_hit),
      .xpos(xpos), .ypos(ypos), .dir(dir), .moving(moving), .anim_frame(anim_frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, want);
      end
   endtask

   function automatic exp_t nxt(input int x, input int y, input int d);
      exp_t e;
      e.x = x;
      e.y = y;
      if (d == 0) e.x = (x + S > XMAX) ? (WX ? XMIN : XMAX) : x + S;
      if (d == 1) e.x = (x < XMIN + S) ? (WX ? XMAX : XMIN) : x - S;
      if (d == 2) e.y = (y < YMIN + S) ? (WY ? YMAX : YMIN) : y - S;
      if (d == 3) e.y = (y + S > YMAX) ? (WY ? YMIN : YMAX) : y + S;
      return e;
   endfunction

   task automatic push(input int d);
      sb.push_back(nxt(ex, ey, d));
   endtask

   task automatic commit(input int d);
      exp_t e;
      e  = nxt(ex, ey, d);
      ex = e.x;
      ey = e.y;
      ed = d;
      ea = (ea + 1) % 4;
   endtask

   task automatic tick();
      @(negedge clk) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
   endtask

   task automatic wait_req();
      int   n = 0;
      exp_t e;
      while (!wall_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", wall_req, 1);
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL sb_pop: got query with %0d expected entries", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("wall_x", wall_x, e.x);
         chk("wall_y", wall_y, e.y);
      end
   endtask

   task automatic serve(input logic hit, input int dly, input logic extra);
      logic [9:0] hx;
      wait_req();
      hx = wall_x;
      for (int i = 0; i < dly; i++) begin
         move_tick = extra && (i == 0);
         @(negedge clk);
         chk("req_held", wall_req, 1);
         chk("wall_x_stable", wall_x, hx);
      end
      move_tick = 1'b0;
      wall_ack  = 1'b1;
      wall_hit  = hit;
      @(negedge clk);
      wall_ack = 1'b0;
      wall_hit = 1'b0;
   endtask

   task automatic pulse_btn(input int d);
      @(negedge clk);
      right = (d == 0);
      left  = (d == 1);
      up    = (d == 2);
      down  = (d == 3);
      @(negedge clk);
      {right, left, up, down} = 4'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_xpos", xpos, 450);
      chk("rst_ypos", ypos, 250);
      chk("rst_dir", dir, 0);
      chk("rst_moving", moving, 0);
      chk("rst_anim", anim_frame, 0);
      chk("rst_req", wall_req, 0);
      chk("rst_wall_x", wall_x, 450);
      chk("rst_wall_y", wall_y, 250);
      rst = 1'b0;
      // first forward move
      @(negedge clk) right = 1'b1;
      push(0);
      tick();
      serve(1'b0, 0, 1'b0);
      commit(0);
      chk("mv1_xpos", xpos, 452);
      chk("mv1_dir", dir, 0);
      chk("mv1_moving", moving, 1);
      chk("mv1_anim", anim_frame, 1);
      // run right until the tunnel wraps to the left edge
      for (int i = 0; i < 200 && ex != XMIN; i++) begin
         push(0);
         tick();
         serve(1'b0, 0, 1'b0);
         commit(0);
      end
      right = 1'b0;
      chk("wrapR_xpos", xpos, 150);
      chk("wrapR_anim", anim_frame, ea);
      // left at the left edge wraps to the right edge
      pulse_btn(1);
      push(1);
      tick();
      serve(1'b0, 0, 1'b0);
      commit(1);
      chk("wrapL_xpos", xpos, 770);
      chk("wrapL_dir", dir, 1);
      chk("wrapL_anim", anim_frame, ea);
      // turn back to right, wrapping again
      pulse_btn(0);
      push(0);
      tick();
      serve(1'b0, 0, 1'b0);
      commit(0);
      chk("turnR_xpos", xpos, 150);
      chk("turnR_dir", dir, 0);
      // blocked turn up falls back to forward, turn stays queued
      pulse_btn(2);
      push(2);
      push(0);
      tick();
      serve(1'b1, 0, 1'b0);
      serve(1'b0, 0, 1'b0);
      commit(0);
      chk("blk_xpos", xpos, 152);
      chk("blk_ypos", ypos, 250);
      chk("blk_dir", dir, 0);
      chk("blk_anim", anim_frame, ea);
      push(2);
      tick();
      serve(1'b0, 0, 1'b0);
      commit(2);
      chk("up_ypos", ypos, 248);
      chk("up_xpos", xpos, 152);
      chk("up_dir", dir, 2);
      // forward query hits a wall
      push(2);
      tick();
      serve(1'b1, 0, 1'b0);
      chk("hit_ypos", ypos, 248);
      chk("hit_xpos", xpos, 152);
      chk("hit_moving", moving, 0);
      chk("hit_anim", anim_frame, ea);
      // extra tick during a slow query is dropped
      push(2);
      tick();
      serve(1'b0, 5, 1'b1);
      commit(2);
      for (int i = 0; i < 8; i++) begin
         chk("no_2nd_req", wall_req, 0);
         @(negedge clk);
      end
      chk("drop_ypos", ypos, 246);
      chk("drop_anim", anim_frame, ea);
      chk("drop_moving", moving, 1);
      // async reset mid-query
      push(2);
      tick();
      wait_req();
      #2 rst = 1'b1;
      #1;
      chk("arst_req", wall_req, 0);
      chk("arst_xpos", xpos, 450);
      chk("arst_ypos", ypos, 250);
      @(negedge clk) rst = 1'b0;
      wall_ack = 1'b1;
      @(negedge clk) wall_ack = 1'b0;
      @(negedge clk);
      chk("late_xpos", xpos, 450);
      chk("late_ypos", ypos, 250);
      chk("late_req", wall_req, 0);
      chk("late_dir", dir, 0);
      chk("late_anim", anim_frame, 0);
      chk("late_moving", moving, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
